// File: rtl/user_proj_example_ann_if.sv
// Link between the Caravel shell and the ann_core search engine.
// It carries the input word stream, the result stream, the control pulses
// and the core's done flag. The shell is the master and the core is the slave.
interface user_proj_example_ann_if #(
  parameter int DATA_WIDTH = 11
);
  logic [DATA_WIDTH-1:0] core_in_data;
  logic                  core_in_valid;
  logic                  core_in_ready;
  logic [DATA_WIDTH-1:0] core_out_data;
  logic                  core_out_valid;
  logic                  core_out_ready;
  logic                  core_load_kdtree;
  logic                  core_fsm_start;
  logic                  core_send_best_arr;
  logic                  core_done;

  modport master (
    output core_in_data, core_in_valid, core_out_ready,
           core_load_kdtree, core_fsm_start, core_send_best_arr,
    input  core_in_ready, core_out_data, core_out_valid, core_done
  );

  modport slave (
    input  core_in_data, core_in_valid, core_out_ready,
           core_load_kdtree, core_fsm_start, core_send_best_arr,
    output core_in_ready, core_out_data, core_out_valid, core_done
  );
endinterface

// File: rtl/user_proj_example_ann.sv
// Caravel shell for the Fast-ANN accelerator. It buffers the pad word stream
// into ann_core and drains results through a first-word-fall-through FIFO.
// It also turns the pad control levels into core pulses, tracks run status,
// and exposes status over Wishbone, the logic analyzer and an interrupt.
module user_proj_example_ann #(
  parameter int BITS       = 32,
  parameter int DATA_WIDTH = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [BITS-1:0]  wbs_dat_o,
  input  logic [127:0]     la_data_in,
  input  logic [127:0]     la_oenb,
  output logic [127:0]     la_data_out,
  input  logic [37:0]      io_in,
  output logic [37:0]      io_out,
  output logic [37:0]      io_oeb,
  output logic [2:0]       irq,
  user_proj_example_ann_if.master core
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [31:0] ADDR_STATUS = 32'h3000_0000;
  localparam logic [31:0] ADDR_OUTCNT = 32'h3000_0004;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Pad decode
  logic                  in_wenq;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  out_deq;
  assign in_wenq  = io_in[2];
  assign in_wdata = io_in[3 +: DATA_WIDTH];
  assign out_deq  = io_in[14];

  // Control edge detection: bit 0 fsm_start, bit 1 send_best_arr, bit 2 load_kdtree
  logic [2:0] ctl_lvl_q, ctl_lvl_d;
  logic [2:0] ctl_pulse_q, ctl_pulse_d;
  logic       start_pulse, load_pulse;

  // Input FIFO
  logic [DATA_WIDTH-1:0] in_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      in_wptr_q, in_wptr_d;
  logic [PTR_W-1:0]      in_rptr_q, in_rptr_d;
  logic                  in_full_n_q, in_full_n_d;
  logic                  in_empty, in_full, in_push, in_pop, ovf_set;
  logic                  ovf_q, ovf_d;
  logic [15:0]           word_cnt_q, word_cnt_d;

  // Output FIFO
  logic [DATA_WIDTH-1:0] out_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      out_wptr_q, out_wptr_d;
  logic [PTR_W-1:0]      out_rptr_q, out_rptr_d;
  logic                  out_empty, out_full, out_push, out_pop;
  logic [DATA_WIDTH-1:0] out_rdata;
  logic                  out_rempty_n;
  logic [15:0]           out_cnt_q, out_cnt_d;

  // Status FSM
  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   irq_q, irq_d;

  // Wishbone
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic            ack_q, ack_d;
  logic [BITS-1:0] dat_q, dat_d;

  logic [31:0] status_word;

  // Flag helpers derived from the pointer registers
  assign in_empty  = (in_wptr_q == in_rptr_q);
  assign in_full   = (in_wptr_q[AW] != in_rptr_q[AW]) &&
                     (in_wptr_q[AW-1:0] == in_rptr_q[AW-1:0]);
  assign out_empty = (out_wptr_q == out_rptr_q);
  assign out_full  = (out_wptr_q[AW] != out_rptr_q[AW]) &&
                     (out_wptr_q[AW-1:0] == out_rptr_q[AW-1:0]);

  assign start_pulse = ctl_pulse_q[0];
  assign load_pulse  = ctl_pulse_q[2];

  // A pop frees the slot, so a push into a full FIFO still lands when the core drains it that cycle
  assign in_pop   = ~in_empty & core.core_in_ready;
  assign in_push  = in_wenq & (~in_full | in_pop);
  assign ovf_set  = in_wenq & in_full & ~in_pop;

  assign out_push = core.core_out_valid & ~out_full;
  assign out_pop  = out_deq & ~out_empty;

  assign status_word = {14'b0, ovf_q, done_q, word_cnt_q};

  // Next-state logic for control pulses, both FIFOs and the counters
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ctl_lvl_d   = io_in[17:15];
    ctl_pulse_d = io_in[17:15] & ~ctl_lvl_q;

    in_wptr_d   = in_wptr_q + PTR_W'(in_push);
    in_rptr_d   = in_rptr_q + PTR_W'(in_pop);
    in_full_n_d = ((in_wptr_d - in_rptr_d) != PTR_W'(FIFO_DEPTH));

    out_wptr_d  = out_wptr_q + PTR_W'(out_push);
    out_rptr_d  = out_rptr_q + PTR_W'(out_pop);

    word_cnt_d  = word_cnt_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q | ovf_set;
    if (in_push) word_cnt_d = word_cnt_q + 16'd1;
    if (out_pop) out_cnt_d  = out_cnt_q + 16'd1;
    if (load_pulse) begin
      word_cnt_d = '0;
      out_cnt_d  = '0;
      ovf_d      = 1'b0;
    end
  end

  // Status FSM next state; done and irq are registered from the next state
  always_comb begin
    state_d = state_q;
    if (start_pulse) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN:  if (core.core_done) state_d = ST_DONE;
        ST_DONE: if (load_pulse)     state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
    done_d = (state_d == ST_DONE);
    irq_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // Wishbone: capture the request, then answer one edge later with a single-cycle ack
  always_comb begin
    req_d = wbs_stb_i & wbs_cyc_i & ~req_q & ~ack_q;
    we_d  = req_d ? wbs_we_i  : we_q;
    adr_d = req_d ? wbs_adr_i : adr_q;
    ack_d = req_q;
    dat_d = '0;
    if (req_q && !we_q) begin
      if (adr_q == ADDR_STATUS)      dat_d = BITS'(status_word);
      else if (adr_q == ADDR_OUTCNT) dat_d = BITS'({out_cnt_q, 16'b0});
    end
  end

  // FIFO storage
  always_ff @(posedge wb_clk_i) begin
    // NOTE: storage has no reset; pointer reset alone empties the FIFOs and discards contents.
    if (in_push)  in_mem[in_wptr_q[AW-1:0]]   <= in_wdata;
    if (out_push) out_mem[out_wptr_q[AW-1:0]] <= core.core_out_data;
  end

  // All control state, with synchronous active-high reset
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst_i) begin
      ctl_lvl_q   <= '0;
      ctl_pulse_q <= '0;
      in_wptr_q   <= '0;
      in_rptr_q   <= '0;
      in_full_n_q <= 1'b0;
      ovf_q       <= 1'b0;
      word_cnt_q  <= '0;
      out_wptr_q  <= '0;
      out_rptr_q  <= '0;
      out_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      ctl_lvl_q   <= ctl_lvl_d;
      ctl_pulse_q <= ctl_pulse_d;
      in_wptr_q   <= in_wptr_d;
      in_rptr_q   <= in_rptr_d;
      in_full_n_q <= in_full_n_d;
      ovf_q       <= ovf_d;
      word_cnt_q  <= word_cnt_d;
      out_wptr_q  <= out_wptr_d;
      out_rptr_q  <= out_rptr_d;
      out_cnt_q   <= out_cnt_d;
      state_q     <= state_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
      req_q       <= req_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  // Core link
  assign core.core_in_data       = in_mem[in_rptr_q[AW-1:0]];
  assign core.core_in_valid      = ~in_empty;
  assign core.core_out_ready     = ~out_full;
  assign core.core_fsm_start     = ctl_pulse_q[0];
  assign core.core_send_best_arr = ctl_pulse_q[1];
  assign core.core_load_kdtree   = ctl_pulse_q[2];

  // Result head is forced to 0 when empty so the pads never show stale storage
  assign out_rdata    = out_empty ? '0 : out_mem[out_rptr_q[AW-1:0]];
  assign out_rempty_n = ~out_empty;

  // Pads, bus, logic analyzer and interrupts
  assign io_out      = {6'b0, done_q, out_rempty_n, out_rdata, in_full_n_q, 18'b0};
  assign io_oeb      = {6'h3F, 14'b0, 18'h3FFFF};
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign la_data_out = {96'b0, status_word};
  assign irq         = {2'b0, irq_q};

  logic unused_inputs;
  assign unused_inputs = ^{io_in[1:0], io_in[37:18], la_data_in, la_oenb,
                           wbs_sel_i, wbs_dat_i};

endmodule

// File: tb/tb_user_proj_example_ann.sv
// Directed bench for user_proj_example_ann. The bench plays the role of ann_core
// on the interface and of the Wishbone master and pad harness on the plain ports.
module tb_user_proj_example_ann;

  logic         clk = 1'b0;
  logic         rst;
  logic         stb, cyc, we;
  logic [3:0]   sel;
  logic [31:0]  dat_w, adr;
  logic         ack;
  logic [31:0]  dat_r;
  logic [127:0] la_in, la_oenb, la_out;
  logic [37:0]  io_in, io_out, io_oeb;
  logic [2:0]   irq;

  always #5 clk = ~clk;

  user_proj_example_ann_if core_if ();

  user_proj_example_ann dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (dat_w),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_r),
    .la_data_in  (la_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_out),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .irq         (irq),
    .core        (core_if.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core-side monitor on the falling edge, where every input has settled
  logic [10:0] rx_q[$];
  int load_pulses = 0, start_pulses = 0, irq_pulses = 0;
  always @(negedge clk) begin
    if (core_if.core_in_valid && core_if.core_in_ready) rx_q.push_back(core_if.core_in_data);
    if (core_if.core_load_kdtree) load_pulses++;
    if (core_if.core_fsm_start)   start_pulses++;
    if (irq[0])                   irq_pulses++;
  end

  // Inputs change 1 time unit after the rising edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One Wishbone access; lat counts edges until ack, ack_after is ack one cycle later
  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rdata, output int lat, output logic ack_after);
    adr = a; we = w; dat_w = d; stb = 1'b1; cyc = 1'b1;
    lat = 0;
    rdata = '0;
    while (lat < 10) begin
      tick();
      lat++;
      if (ack) break;
    end
    rdata = dat_r;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick();
    ack_after = ack;
  endtask

  task automatic wb_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    logic        ack_after;
    wb_access(a, 1'b0, 32'h0, rd, lat, ack_after);
    check({tag, "_data"}, rd, exp);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_ack_width"}, ack_after, 1'b0);
  endtask

  task automatic push_word(input logic [10:0] w);
    io_in[2]    = 1'b1;
    io_in[13:3] = w;
    tick();
    io_in[2]    = 1'b0;
  endtask

  // Watchdog: a hang is reported and stops the run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [10:0] exp_out [3];
    logic [31:0] rd;
    int          lat;
    logic        ack_after;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
    dat_w = '0; adr = '0; la_in = '0; la_oenb = '0; io_in = '0;
    core_if.core_in_ready  = 1'b0;
    core_if.core_out_valid = 1'b0;
    core_if.core_out_data  = '0;
    core_if.core_done      = 1'b0;

    // Reset state
    tick(2);
    check("rst_io_out", io_out, 38'h0);
    check("rst_io_oeb", io_oeb, 38'h3F0003FFFF);
    check("rst_irq", irq, 3'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_la", la_out, 128'h0);
    rst = 1'b0;
    tick();
    check("post_rst_wfull_n", io_out[18], 1'b1);
    wb_read_check("rst_status", 32'h3000_0000, 32'h0);

    // Input stream: 126 words with the core always ready
    core_if.core_in_ready = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 126; i++) begin
      io_in[2]    = 1'b1;
      io_in[13:3] = 11'(i);
      tick();
    end
    io_in[2] = 1'b0;
    tick(4);
    check("stream_count", rx_q.size(), 126);
    for (int i = 0; i < 126 && i < rx_q.size(); i++)
      check($sformatf("stream_word%0d", i), rx_q[i], 11'(i));
    wb_read_check("stream_status", 32'h3000_0000, 32'h0000_007E);

    // Overflow: core stalled, 10 pushes, only 8 fit
    core_if.core_in_ready = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      push_word(11'(i));
      if (i == 6) check("ovf_wfull_n_at7", io_out[18], 1'b1);
      if (i == 7) check("ovf_wfull_n_at8", io_out[18], 1'b0);
    end
    tick();
    check("ovf_wfull_n_hold", io_out[18], 1'b0);
    wb_read_check("ovf_status", 32'h3000_0000, 32'h0002_0086);
    core_if.core_in_ready = 1'b1;
    tick(12);
    check("ovf_count", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check($sformatf("ovf_word%0d", i), rx_q[i], 11'(i));
    check("ovf_wfull_n_free", io_out[18], 1'b1);

    // Output stream with out_deq held high
    exp_out[0] = 11'h7FF; exp_out[1] = 11'h001; exp_out[2] = 11'h400;
    check("out_empty_before", io_out[30], 1'b0);
    core_if.core_out_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      core_if.core_out_data = exp_out[k];
      check($sformatf("out_ready%0d", k), core_if.core_out_ready, 1'b1);
      tick();
    end
    core_if.core_out_valid = 1'b0;
    check("out_rempty_n_filled", io_out[30], 1'b1);
    io_in[14] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out_rdata%0d", k), io_out[29:19], exp_out[k]);
      check($sformatf("out_rempty_n%0d", k), io_out[30], 1'b1);
      tick();
    end
    check("out_drained", io_out[30], 1'b0);
    tick();
    io_in[14] = 1'b0;
    tick();
    wb_read_check("out_cnt", 32'h3000_0004, 32'h0003_0000);

    // FSM: start, core done after 50 cycles, then load_kdtree back to idle
    start_pulses = 0;
    irq_pulses   = 0;
    io_in[15] = 1'b1;
    tick();
    io_in[15] = 1'b0;
    tick(49);
    check("fsm_run_done_low", io_out[31], 1'b0);
    core_if.core_done = 1'b1;
    check("fsm_done_same_cycle", io_out[31], 1'b0);
    tick();
    check("fsm_done_rise", io_out[31], 1'b1);
    check("fsm_irq_rise", irq[0], 1'b1);
    core_if.core_done = 1'b0;
    tick();
    check("fsm_irq_fall", irq[0], 1'b0);
    check("fsm_done_hold", io_out[31], 1'b1);
    tick(3);
    check("fsm_irq_pulses", irq_pulses, 1);
    check("fsm_start_pulses", start_pulses, 1);
    wb_read_check("fsm_status", 32'h3000_0000, 32'h0003_0086);

    load_pulses = 0;
    io_in[17] = 1'b1;
    tick(3);
    io_in[17] = 1'b0;
    tick(2);
    check("load_pulses", load_pulses, 1);
    check("load_done_low", io_out[31], 1'b0);
    wb_read_check("load_status", 32'h3000_0000, 32'h0);
    wb_read_check("load_out_cnt", 32'h3000_0004, 32'h0);

    // Full FIFO: push and pop in the same cycle both happen, no overflow
    core_if.core_in_ready = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 8; i++) push_word(11'h100 + 11'(i));
    check("full_wfull_n", io_out[18], 1'b0);
    core_if.core_in_ready = 1'b1;
    push_word(11'h055);
    tick(10);
    check("full_count", rx_q.size(), 9);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check($sformatf("full_word%0d", i), rx_q[i], 11'h100 + 11'(i));
    if (rx_q.size() > 8) check("full_word8", rx_q[8], 11'h055);
    wb_read_check("full_status", 32'h3000_0000, 32'h0000_0009);
    check("la_status", la_out[31:0], 32'h0000_0009);
    check("la_upper", la_out[127:32], 96'h0);

    // Wishbone: unmapped read returns 0, writes are acknowledged and ignored
    wb_read_check("wb_unmapped", 32'h3000_0008, 32'h0);
    wb_access(32'h3000_0000, 1'b1, 32'hFFFF_FFFF, rd, lat, ack_after);
    check("wb_write_lat", lat, 2);
    check("wb_write_ack_width", ack_after, 1'b0);
    wb_read_check("wb_after_write", 32'h3000_0000, 32'h0000_0009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
